// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the architectural PC and issues one instruction fetch at a time.
// Optional feature macro: PC_MISALIGN_CHECK_EN (misaligned redirects trap to TRAP_VEC).
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    output logic        misalign_trap
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; a producer
    // holds valid and payload stable until the transfer (a redirect may replace the
    // request address). Responses carry no ready and arrive once per accepted request.
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        squash_q, squash_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        trap_q, trap_d;

    logic        redirect_en;
    logic        misaligned;
    logic [31:0] redirect_pc;
    logic        fire;

    assign redirect_en = redirect_valid && (state_q != IDLE);
    assign fire        = buf_valid_q && if_ready;

`ifdef PC_MISALIGN_CHECK_EN
    assign misaligned = (redirect_target[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif
    assign redirect_pc = misaligned ? TRAP_VEC : redirect_target;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        squash_d    = squash_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        trap_d      = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                    // Accepted address is now stale; its response must be dropped.
                    if (redirect_en) squash_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    state_d = REQ;
                    if (squash_q || redirect_en) begin
                        squash_d = 1'b0;
                    end else begin
                        buf_valid_d = 1'b1;
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem_resp_data;
                        pc_d        = pc_q + 32'd4;
                        state_d     = HOLD;
                    end
                end else if (redirect_en) begin
                    squash_d = 1'b1;
                end
            end
            HOLD: begin
                if (fire) begin
                    buf_valid_d = 1'b0;
                    state_d     = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides sequential PC update and flushes the skid buffer.
        if (redirect_en) begin
            pc_d        = redirect_pc;
            buf_valid_d = 1'b0;
            trap_d      = misaligned;
            if (state_q == HOLD) state_d = REQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            squash_q    <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= 32'd0;
            buf_instr_q <= 32'd0;
            trap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            squash_q    <= squash_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            trap_q      <= trap_d;
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign if_valid       = buf_valid_q;
    assign if_pc          = buf_pc_q;
    assign if_instr       = buf_instr_q;
    assign misalign_trap  = trap_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: behavioural memory with configurable latency,
// request/consume logs and hand-computed expected addresses.
module tb_fetch_sequencer;

    localparam logic [31:0] KEY = 32'hC0DE_0000;
`ifdef PC_MISALIGN_CHECK_EN
    localparam logic        EXP_TRAP = 1'b1;
    localparam logic [31:0] EXP_MIS_ADDR = 32'h0000_0100;
`else
    localparam logic        EXP_TRAP = 1'b0;
    localparam logic [31:0] EXP_MIS_ADDR = 32'h0000_2002;
`endif

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        misalign_trap;

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat  = 1;

    logic [31:0] req_log[$];
    logic [31:0] fire_log[$];
    logic [31:0] fire_instr[$];

    fetch_sequencer #(.RESET_PC(32'h0000_1000), .TRAP_VEC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
        .misalign_trap(misalign_trap)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model and monitor: sample at negedge, respond just after the next posedge.
    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        logic        busy;
        int          cnt;
        logic [31:0] addr;
        busy = 1'b0; cnt = 0; addr = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            acc      = !rst && imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            if (acc) req_log.push_back(imem_req_addr);
            if (!rst && if_valid && if_ready) begin
                fire_log.push_back(if_pc);
                fire_instr.push_back(if_instr);
            end
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (rst) begin
                busy = 1'b0;
            end else begin
                if (acc) begin
                    busy = 1'b1; cnt = mem_lat; addr = acc_addr;
                end
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data  = addr ^ KEY;
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        redirect_valid = 1'b0;
        @(negedge clk); #1;
        req_log.delete(); fire_log.delete(); fire_instr.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        @(posedge clk); #1;
        redirect_valid  = 1'b1;
        redirect_target = target;
        @(posedge clk); #1;
        redirect_valid  = 1'b0;
    endtask

    task automatic wait_accepts(input int n);
        int k = 0;
        while (req_log.size() < n && k < 200) begin
            @(negedge clk); #1; k++;
        end
        check("accept_timeout", 32'(req_log.size() >= n), 32'd1);
    endtask

    task automatic wait_fires(input int n);
        int k = 0;
        while (fire_log.size() < n && k < 200) begin
            @(negedge clk); #1; k++;
        end
        check("fire_timeout", 32'(fire_log.size() >= n), 32'd1);
    endtask

    task automatic wait_if_valid();
        int k = 0;
        while (!if_valid && k < 200) begin
            @(negedge clk); #1; k++;
        end
        check("if_valid_timeout", 32'(if_valid), 32'd1);
    endtask

    task automatic wait_req_valid();
        int k = 0;
        while (!imem_req_valid && k < 200) begin
            @(negedge clk); #1; k++;
        end
        check("req_valid_timeout", 32'(imem_req_valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = '0;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;

        // reset values
        @(negedge clk); #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0000_1000);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_trap", 32'(misalign_trap), 32'd0);

        // sequential fetch, always ready
        do_reset();
        wait_fires(3);
        check("seq_req0", req_log[0], 32'h0000_1000);
        check("seq_req1", req_log[1], 32'h0000_1004);
        check("seq_req2", req_log[2], 32'h0000_1008);
        check("seq_pc0", fire_log[0], 32'h0000_1000);
        check("seq_pc1", fire_log[1], 32'h0000_1004);
        check("seq_pc2", fire_log[2], 32'h0000_1008);
        check("seq_instr1", fire_instr[1], 32'h0000_1004 ^ KEY);

        // decode stall holds the buffer, no new request
        if_ready = 1'b0;
        do_reset();
        check("midrst_if_valid", 32'(if_valid), 32'd0);
        check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        wait_if_valid();
        for (int i = 0; i < 5; i++) begin
            check("stall_if_valid", 32'(if_valid), 32'd1);
            check("stall_if_pc", if_pc, 32'h0000_1000);
            check("stall_no_req", 32'(imem_req_valid), 32'd0);
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        if_ready = 1'b1;
        wait_accepts(2);
        check("stall_next_req", req_log[1], 32'h0000_1004);
        check("stall_fire_pc", fire_log[0], 32'h0000_1000);

        // redirect while waiting on 0x1004 (response coincides with the redirect)
        pulse_redirect(32'h0000_2000);
        wait_fires(2);
        check("redir_req", req_log[2], 32'h0000_2000);
        check("redir_fire_pc", fire_log[1], 32'h0000_2000);
        check("redir_instr", fire_instr[1], 32'h0000_2000 ^ KEY);

        // redirect with a slow response: squashed response never reaches decode
        mem_lat = 3;
        wait_accepts(4);
        check("squash_pre_req", req_log[3], 32'h0000_2004);
        pulse_redirect(32'h0000_2800);
        wait_fires(3);
        check("squash_req", req_log[4], 32'h0000_2800);
        check("squash_fire_pc", fire_log[2], 32'h0000_2800);
        check("squash_instr", fire_instr[2], 32'h0000_2800 ^ KEY);
        mem_lat = 1;

        // redirect while holding an instruction flushes the buffer
        @(posedge clk); #1;
        if_ready = 1'b0;
        wait_if_valid();
        check("hold_pc", if_pc, 32'h0000_2804);
        pulse_redirect(32'h0000_4000);
        @(negedge clk); #1;
        check("hold_flush_valid", 32'(if_valid), 32'd0);
        check("hold_flush_req", 32'(imem_req_valid), 32'd1);
        check("hold_flush_addr", imem_req_addr, 32'h0000_4000);
        if_ready = 1'b1;

        // request not accepted; redirect replaces the pending address
        imem_req_ready = 1'b0;
        do_reset();
        wait_req_valid();
        check("noacc_addr0", imem_req_addr, 32'h0000_1000);
        @(negedge clk); #1;
        check("noacc_stable", imem_req_addr, 32'h0000_1000);
        pulse_redirect(32'h0000_3000);
        @(negedge clk); #1;
        check("noacc_valid", 32'(imem_req_valid), 32'd1);
        check("noacc_addr1", imem_req_addr, 32'h0000_3000);
        @(posedge clk); #1;
        imem_req_ready = 1'b1;
        wait_fires(1);
        check("noacc_only_one", 32'(req_log.size()), 32'd1);
        check("noacc_req", req_log[0], 32'h0000_3000);
        check("noacc_fire_pc", fire_log[0], 32'h0000_3000);

        // PC wrap at the top of the address space
        imem_req_ready = 1'b0;
        do_reset();
        wait_req_valid();
        pulse_redirect(32'hFFFF_FFFC);
        @(posedge clk); #1;
        imem_req_ready = 1'b1;
        wait_fires(2);
        check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
        check("wrap_req1", req_log[1], 32'h0000_0000);
        check("wrap_fire_pc", fire_log[1], 32'h0000_0000);

        // misaligned redirect
        imem_req_ready = 1'b0;
        do_reset();
        wait_req_valid();
        pulse_redirect(32'h0000_2002);
        @(negedge clk); #1;
        check("mis_trap", 32'(misalign_trap), 32'(EXP_TRAP));
        check("mis_addr", imem_req_addr, EXP_MIS_ADDR);
        @(negedge clk); #1;
        check("mis_trap_pulse", 32'(misalign_trap), 32'd0);
        @(posedge clk); #1;
        imem_req_ready = 1'b1;
        wait_accepts(1);
        check("mis_req", req_log[0], EXP_MIS_ADDR);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
